// File: rtl/line_transfer_engine.sv
// Cache-line transfer engine: master on the main-memory command/data handshake.
// Turns one cache-line request (fill, write-back, or write-back then fill) into a
// line-aligned memory command followed by a burst of WORDS_PER_LINE 32-bit beats,
// returns the filled line and reports a timeout abort via o_resp_err.
//
// Ports:
//   i_clk, i_rst_n                      clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready           cache request handshake (ready only in idle)
//   i_req_type                          00 fill, 01 write-back, 10 wb then fill, 11 fill
//   i_req_addr, i_req_wb_addr           fill / victim byte addresses
//   i_line_wdata                        victim line, word i at [32i+31:32i]
//   o_resp_valid, o_resp_err            one-cycle completion pulse, error qualifier
//   o_line_rdata                        filled line, same packing as i_line_wdata
//   o_mem_cmd_*  / i_mem_cmd_ready      memory command channel
//   o_mem_wdata* / i_mem_wdata_ready    memory write-beat channel
//   i_mem_rdata_valid, i_mem_rdata      memory read-beat channel (always accepted)
module line_transfer_engine #(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [1:0]                   i_req_type,
    input  logic [31:0]                  i_req_addr,
    input  logic [31:0]                  i_req_wb_addr,
    input  logic [WORDS_PER_LINE*32-1:0] i_line_wdata,
    output logic                         o_resp_valid,
    output logic                         o_resp_err,
    output logic [WORDS_PER_LINE*32-1:0] o_line_rdata,
    output logic                         o_mem_cmd_valid,
    input  logic                         i_mem_cmd_ready,
    output logic                         o_mem_cmd_write,
    output logic [31:0]                  o_mem_cmd_addr,
    output logic                         o_mem_wdata_valid,
    input  logic                         i_mem_wdata_ready,
    output logic [31:0]                  o_mem_wdata,
    input  logic                         i_mem_rdata_valid,
    input  logic [31:0]                  i_mem_rdata
);

    localparam int unsigned IdxW  = $clog2(WORDS_PER_LINE);
    localparam int unsigned BeatW = IdxW + 1;
    localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0]       AlignMask = ~(32'(WORDS_PER_LINE * 4) - 32'd1);
    localparam logic [BeatW-1:0]  LastBeat  = BeatW'(WORDS_PER_LINE - 1);
    localparam logic [CntW-1:0]   CntLast   = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StWbCmd, StWbData, StRdCmd, StRdData, StResp} state_e;

    state_e                         r_state, w_state_next;
    logic                           r_req_ready;
    logic [BeatW-1:0]               r_beat, w_beat_next;
    logic [CntW-1:0]                r_cnt, w_cnt_next;
    logic                           r_err, w_err_next;
    logic                           w_stall;
    logic                           w_accept;
    logic                           w_req_wb;
    logic [31:0]                    r_fill_addr, r_wb_addr;
    logic                           r_wb_then_fill;
    logic [WORDS_PER_LINE-1:0][31:0] r_wdata;
    logic [WORDS_PER_LINE-1:0][31:0] r_line_rdata;

    assign w_accept = i_req_valid && r_req_ready;
    assign w_req_wb = (i_req_type == 2'b01) || (i_req_type == 2'b10);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b0;
            r_beat      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == StIdle);
            r_beat      <= w_beat_next;
            r_cnt       <= w_cnt_next;
            r_err       <= w_err_next;
        end
    end

    // Next-state logic. The timeout counter defaults to 0, so every handshake and
    // every state change clears it; only a stalled cycle advances it.
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_cnt_next   = '0;
        w_err_next   = r_err;
        w_stall      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_err_next   = 1'b0;
                    w_state_next = w_req_wb ? StWbCmd : StRdCmd;
                end
            end
            StWbCmd: begin
                if (i_mem_cmd_ready) begin
                    w_state_next = StWbData;
                    w_beat_next  = '0;
                end else begin
                    w_stall = 1'b1;
                end
            end
            StWbData: begin
                if (i_mem_wdata_ready) begin
                    if (r_beat == LastBeat) begin
                        w_state_next = r_wb_then_fill ? StRdCmd : StResp;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            StRdCmd: begin
                if (i_mem_cmd_ready) begin
                    w_state_next = StRdData;
                    w_beat_next  = '0;
                end else begin
                    w_stall = 1'b1;
                end
            end
            StRdData: begin
                if (i_mem_rdata_valid) begin
                    if (r_beat == LastBeat) begin
                        w_state_next = StResp;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        if (w_stall) begin
            if (r_cnt == CntLast) begin
                w_state_next = StResp;
                w_err_next   = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // Request capture and fill-data storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill_addr    <= '0;
            r_wb_addr      <= '0;
            r_wb_then_fill <= 1'b0;
            r_wdata        <= '0;
            r_line_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_fill_addr    <= i_req_addr & AlignMask;
                r_wb_addr      <= i_req_wb_addr & AlignMask;
                r_wb_then_fill <= (i_req_type == 2'b10);
                r_wdata        <= i_line_wdata;
            end
            if (r_state == StRdData && i_mem_rdata_valid) begin
                r_line_rdata[r_beat[IdxW-1:0]] <= i_mem_rdata;
            end
        end
    end

    // Outputs decoded from state only, so they are all 0 while reset holds IDLE
    always_comb begin
        o_mem_cmd_valid   = 1'b0;
        o_mem_cmd_write   = 1'b0;
        o_mem_cmd_addr    = '0;
        o_mem_wdata_valid = 1'b0;
        o_mem_wdata       = '0;
        o_resp_valid      = 1'b0;
        o_resp_err        = 1'b0;
        unique case (r_state)
            StWbCmd: begin
                o_mem_cmd_valid = 1'b1;
                o_mem_cmd_write = 1'b1;
                o_mem_cmd_addr  = r_wb_addr;
            end
            StWbData: begin
                o_mem_wdata_valid = 1'b1;
                o_mem_wdata       = r_wdata[r_beat[IdxW-1:0]];
            end
            StRdCmd: begin
                o_mem_cmd_valid = 1'b1;
                o_mem_cmd_addr  = r_fill_addr;
            end
            StResp: begin
                o_resp_valid = 1'b1;
                o_resp_err   = r_err;
            end
            default: ;
        endcase
    end

    assign o_req_ready  = r_req_ready;
    assign o_line_rdata = r_line_rdata;

endmodule

// File: tb/tb_line_transfer_engine.sv
module tb_line_transfer_engine;

    localparam int W  = 8;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_type = '0;
    logic [31:0]    req_addr = '0;
    logic [31:0]    req_wb_addr = '0;
    logic [W*32-1:0] line_wdata = '0;
    logic           resp_valid;
    logic           resp_err;
    logic [W*32-1:0] line_rdata;
    logic           mem_cmd_valid;
    logic           mem_cmd_ready = 1'b0;
    logic           mem_cmd_write;
    logic [31:0]    mem_cmd_addr;
    logic           mem_wdata_valid;
    logic           mem_wdata_ready = 1'b0;
    logic [31:0]    mem_wdata;
    logic           mem_rdata_valid = 1'b0;
    logic [31:0]    mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W*32-1:0] exp_line = '0;

    line_transfer_engine #(
        .WORDS_PER_LINE (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_type        (req_type),
        .i_req_addr        (req_addr),
        .i_req_wb_addr     (req_wb_addr),
        .i_line_wdata      (line_wdata),
        .o_resp_valid      (resp_valid),
        .o_resp_err        (resp_err),
        .o_line_rdata      (line_rdata),
        .o_mem_cmd_valid   (mem_cmd_valid),
        .i_mem_cmd_ready   (mem_cmd_ready),
        .o_mem_cmd_write   (mem_cmd_write),
        .o_mem_cmd_addr    (mem_cmd_addr),
        .o_mem_wdata_valid (mem_wdata_valid),
        .i_mem_wdata_ready (mem_wdata_ready),
        .o_mem_wdata       (mem_wdata),
        .i_mem_rdata_valid (mem_rdata_valid),
        .i_mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~(32'(W * 4) - 32'd1);
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("req_ready_wait", req_ready, 1'b1);
    endtask

    // mode 0: memory always ready; 1: random bounded backpressure;
    // 2: command ready after 3 stalls, write ready toggling.
    // rd_base != 0 makes read beat i return rd_base + i, otherwise random.
    task automatic run_req(input logic [1:0] typ, input logic [31:0] addr,
                           input logic [31:0] wb_addr, input logic [W*32-1:0] wline,
                           input int mode, input bit extra_beat, input logic [31:0] rd_base);
        logic [31:0] exp_addr[$];
        bit          exp_wr[$];
        logic [31:0] exp_wbeats[$];
        logic [31:0] got_addr[$];
        bit          got_wr[$];
        logic [31:0] got_wbeats[$];
        logic [31:0] rd_vals[$];
        bit has_wb, is_fill, rd_phase, extra_done, done, cmd_pend, cmd_acc, wd_pend, wtog;
        bit cr, wr, rv;
        int resp_cnt, resp_obs, rd_sent, cmd_stall, wd_stall, rd_gap, phases;
        logic resp_err_seen;
        logic [31:0] cmd_addr_prev, wd_prev;

        has_wb  = (typ == 2'b01) || (typ == 2'b10);
        is_fill = (typ != 2'b01);
        if (has_wb) begin
            exp_addr.push_back(align(wb_addr));
            exp_wr.push_back(1'b1);
            for (int i = 0; i < W; i++) exp_wbeats.push_back(wline[i*32 +: 32]);
        end
        if (is_fill) begin
            exp_addr.push_back(align(addr));
            exp_wr.push_back(1'b0);
        end
        rd_phase = 0; extra_done = 0; done = 0; cmd_pend = 0; cmd_acc = 0; wd_pend = 0;
        wtog = 0; resp_cnt = 0; resp_obs = 0; rd_sent = 0; cmd_stall = 0; wd_stall = 0;
        rd_gap = 0; resp_err_seen = 1'b0; cmd_addr_prev = '0; wd_prev = '0;

        wait_ready();
        req_valid   = 1'b1;
        req_type    = typ;
        req_addr    = addr;
        req_wb_addr = wb_addr;
        line_wdata  = wline;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid   = 1'b0;
                req_type    = 2'($urandom);
                req_addr    = $urandom;
                req_wb_addr = $urandom;
                for (int i = 0; i < W; i++) line_wdata[i*32 +: 32] = $urandom;
            end
            if (cmd_pend) begin
                check_eq("cmd_hold_valid", mem_cmd_valid, 1'b1);
                check_eq("cmd_hold_addr", mem_cmd_addr, cmd_addr_prev);
            end
            if (cmd_acc) check_eq("cmd_drop", mem_cmd_valid, 1'b0);
            if (wd_pend) begin
                check_eq("wdata_hold_valid", mem_wdata_valid, 1'b1);
                check_eq("wdata_hold_data", mem_wdata, wd_prev);
            end
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    resp_obs      = k;
                    resp_err_seen = resp_err;
                    check_eq("resp_after_bursts",
                             {got_addr.size(), got_wbeats.size(), rd_sent},
                             {exp_addr.size(), exp_wbeats.size(), is_fill ? W : 0});
                end
            end
            // read beats, only once the read command has been accepted
            if (rd_phase && rd_sent < W) begin
                rv = (mode == 1 && rd_gap < 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_rdata_valid = rv;
                mem_rdata = (rd_base != 0) ? rd_base + 32'(rd_sent) : $urandom;
                if (rv) begin
                    rd_vals.push_back(mem_rdata);
                    rd_sent++;
                    rd_gap = 0;
                end else begin
                    rd_gap++;
                end
            end else if (rd_phase && extra_beat && !extra_done) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = $urandom;
                extra_done      = 1;
            end else begin
                mem_rdata_valid = 1'b0;
            end
            // command channel
            if (mode == 0)      cr = 1'b1;
            else if (mode == 1) cr = (cmd_stall >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            else                cr = (cmd_stall >= 3);
            mem_cmd_ready = cr;
            cmd_acc  = 0;
            cmd_pend = 0;
            if (mem_cmd_valid) begin
                if (cr) begin
                    got_addr.push_back(mem_cmd_addr);
                    got_wr.push_back(mem_cmd_write);
                    cmd_acc   = 1;
                    cmd_stall = 0;
                    if (!mem_cmd_write) rd_phase = 1;
                end else begin
                    cmd_pend      = 1;
                    cmd_addr_prev = mem_cmd_addr;
                    cmd_stall++;
                end
            end
            // write-beat channel
            if (mode == 0)      wr = 1'b1;
            else if (mode == 1) wr = (wd_stall >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            else                wr = wtog;
            wtog = ~wtog;
            mem_wdata_ready = wr;
            wd_pend = 0;
            if (mem_wdata_valid) begin
                if (wr) begin
                    got_wbeats.push_back(mem_wdata);
                    wd_stall = 0;
                end else begin
                    wd_pend = 1;
                    wd_prev = mem_wdata;
                    wd_stall++;
                end
            end
            if (resp_cnt > 0 && k >= resp_obs + 3) done = 1;
        end
        mem_cmd_ready   = 1'b0;
        mem_wdata_ready = 1'b0;
        mem_rdata_valid = 1'b0;

        check_eq("resp_count", resp_cnt, 1);
        check_eq("resp_err", resp_err_seen, 1'b0);
        if (mode == 0) begin
            phases = (has_wb ? 1 : 0) + (is_fill ? 1 : 0);
            check_eq("resp_latency", resp_obs, phases * (W + 1) + 1);
        end
        check_eq("cmd_count", got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check_eq("cmd_addr", got_addr[i], exp_addr[i]);
            check_eq("cmd_write", got_wr[i], exp_wr[i]);
        end
        check_eq("wbeat_count", got_wbeats.size(), exp_wbeats.size());
        for (int i = 0; i < exp_wbeats.size() && i < got_wbeats.size(); i++)
            check_eq("wbeat_data", got_wbeats[i], exp_wbeats[i]);
        if (is_fill && rd_vals.size() == W) begin
            for (int i = 0; i < W; i++) exp_line[i*32 +: 32] = rd_vals[i];
        end
        check_eq("line_rdata", line_rdata, exp_line);
    endtask

    initial begin
        logic [W*32-1:0] wl;
        int vcnt, rcnt;
        bit seen;

        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_cmd_valid", mem_cmd_valid, 1'b0);
        check_eq("rst_wdata_valid", mem_wdata_valid, 1'b0);
        check_eq("rst_resp", {resp_valid, resp_err}, 2'b00);
        check_eq("rst_line", line_rdata, '0);
        check_eq("rst_cmd_addr", mem_cmd_addr, 32'h0);
        rst_n = 1'b1;
        #1 check_eq("ready_before_edge", req_ready, 1'b0);
        @(negedge clk);
        check_eq("ready_first_edge", req_ready, 1'b1);

        // fill, memory always ready, data 0xA0+i
        run_req(2'b00, 32'h0000_0047, 32'h0, '0, 0, 1'b0, 32'hA0);

        // write-back with backpressure
        for (int i = 0; i < W; i++) wl[i*32 +: 32] = 32'h10 + 32'(i);
        run_req(2'b01, 32'h0, 32'h100, wl, 2, 1'b0, 32'h0);

        // write-back then fill
        for (int i = 0; i < W; i++) wl[i*32 +: 32] = $urandom;
        run_req(2'b10, 32'h31C, 32'h200, wl, 0, 1'b0, 32'hB0);

        // timeout on a stalled fill command
        wait_ready();
        req_valid = 1'b1; req_type = 2'b00; req_addr = 32'h0000_0400;
        mem_cmd_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        vcnt = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (mem_cmd_valid) vcnt++;
            if (resp_valid) begin
                seen = 1;
                check_eq("to_resp_err", resp_err, 1'b1);
                check_eq("to_cmd_dropped", mem_cmd_valid, 1'b0);
                @(negedge clk);
                check_eq("to_ready_after", req_ready, 1'b1);
            end else begin
                @(negedge clk);
            end
        end
        check_eq("to_resp_seen", seen, 1'b1);
        check_eq("to_valid_cycles", vcnt, TO);

        // fill with an extra beat after the last one, then stray beats in idle
        run_req(2'b00, $urandom, 32'h0, '0, 0, 1'b1, 32'h0);
        rcnt = 0;
        for (int k = 0; k < 5; k++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            @(negedge clk);
            if (resp_valid) rcnt++;
        end
        mem_rdata_valid = 1'b0;
        check_eq("stray_no_resp", rcnt, 0);
        check_eq("stray_line", line_rdata, exp_line);

        // async reset in the middle of a read burst
        wait_ready();
        req_valid = 1'b1; req_type = 2'b00; req_addr = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_outputs",
                 {req_ready, resp_valid, resp_err, mem_cmd_valid, mem_cmd_write,
                  mem_wdata_valid}, 6'b0);
        check_eq("arst_addr_data", {mem_cmd_addr, mem_wdata}, 64'h0);
        check_eq("arst_line", line_rdata, '0);
        exp_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_ready_first_edge", req_ready, 1'b1);
        mem_cmd_ready = 1'b0;
        rcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rcnt++;
        end
        mem_rdata_valid = 1'b0;
        check_eq("arst_stray_resp", rcnt, 0);
        check_eq("arst_stray_line", line_rdata, '0);
        run_req(2'b00, $urandom, 32'h0, '0, 0, 1'b0, 32'h0);

        // randomized requests under random backpressure
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < W; i++) wl[i*32 +: 32] = $urandom;
            run_req(2'($urandom_range(0, 3)), $urandom, $urandom, wl, 1,
                    1'($urandom_range(0, 1)), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
